puf_challenge_sequencer: RTL
============================

Name: puf_challenge_sequencer

Overview:
- Drives the ring-oscillator PUF through a contiguous challenge range, one evaluation at a time.
- For each challenge: pulses the PUF reset, waits for PUF DONE (with timeout), captures the response, presents it on a valid/ready port, and folds it into a 16-bit running signature.
- Sits between the board top level (switches/button) and the PUF. The signature feeds the seven-segment display; the per-challenge stream feeds logging.

Parameters:
- CHAL_W, 8, challenge width (PUF CHALLENGE bus).
- RESP_W, 8, response width (PUF RESPONSE bus).
- RST_CYCLES, 4, cycles PUF_RESET is held high per evaluation (>=1).
- TIMEOUT, 1048576, max cycles waited for PUF_DONE before declaring timeout.
- TO_W, 21, width of timeout counter (>= clog2(TIMEOUT+1)).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse; begins a sweep; ignored unless IDLE.
- ABORT  in  1  level; ends sweep at next state boundary (see Behaviour).
- CHAL_FIRST  in  CHAL_W  first challenge, sampled on accepted START.
- CHAL_LAST  in  CHAL_W  last challenge, sampled on accepted START.
- PUF_RESET  out  1  active-high reset/start to PUF.
- PUF_CHALLENGE  out  CHAL_W  challenge applied to PUF.
- PUF_DONE  in  1  PUF measurement complete (level).
- PUF_RESPONSE  in  RESP_W  PUF result, valid while PUF_DONE=1.
- RESP_VALID  out  1  per-challenge result available.
- RESP_READY  in  1  consumer accepts result.
- RESP_CHAL  out  CHAL_W  challenge of presented result.
- RESP_DATA  out  RESP_W  presented response (0 on timeout).
- RESP_TO  out  1  presented result timed out.
- SIGNATURE  out  16  running signature of the sweep.
- BUSY  out  1  high in any state except IDLE.
- SWEEP_DONE  out  1  one-cycle pulse when a sweep ends (normal or abort).
- ERR  out  1  sticky: any timeout this sweep; cleared on accepted START.

Behaviour:
- Reset values: all outputs 0; PUF_CHALLENGE=0; state IDLE. Async assert; registers release on the first CLK edge after RESET_N rises. Reset mid-sweep discards everything.
- States: IDLE -> RST -> WAIT -> PRESENT -> (RST | FINISH) -> IDLE.
- IDLE
  - On START: latch FIRST/LAST, set cur=FIRST, clear SIGNATURE and ERR, enter RST.
  - START while not IDLE is ignored.
- RST
  - PUF_RESET=1 for exactly RST_CYCLES cycles; PUF_CHALLENGE=cur, stable from RST entry through PRESENT exit.
  - Then enter WAIT with the timeout counter cleared.
- WAIT
  - PUF_DONE is ignored in the first cycle after PUF_RESET falls (blanking).
  - Thereafter, on PUF_DONE=1: capture PUF_RESPONSE, enter PRESENT.
  - If the counter reaches TIMEOUT first: capture 0, set RESP_TO=1, set ERR, enter PRESENT.
  - DONE and timeout in the same cycle: DONE wins.
- PRESENT
  - RESP_VALID=1; RESP_CHAL/DATA/TO held stable until the handshake (VALID & READY).
  - On handshake: SIGNATURE <= rotl1(SIGNATURE) ^ {RESP_CHAL, RESP_DATA}, zero-extended/truncated to 16 bits.
  - After the handshake: if cur==LAST or ABORT=1, go to FINISH; else cur <= cur+1 (mod 2^CHAL_W) and go to RST.
  - Result is registered, so RESP_VALID rises the cycle after DONE is sampled. READY may be high early; no combinational READY->VALID path.
- ABORT: in RST or WAIT, ABORT=1 goes straight to FINISH; no result presented, no signature update. In PRESENT it is honoured only after the handshake; a pending result is never dropped.
- FINISH: SWEEP_DONE=1 for one cycle, PUF_RESET=0, then IDLE. SIGNATURE and ERR hold until the next accepted START.
- Wrap-around: LAST<FIRST sweeps FIRST..2^CHAL_W-1, then 0..LAST. Count = ((LAST-FIRST) mod 2^CHAL_W)+1. FIRST==LAST gives exactly one evaluation.
- Minimum per-challenge latency with READY=1 and DONE arriving immediately after blanking: RST_CYCLES+3 cycles.

Decomposition:
- Package puf_seq_pkg: state enum (IDLE, RST, WAIT, PRESENT, FINISH), SIG_W=16 constant, signature-update function.
- One natural sub-module, puf_timeout_ctr: clear/enable counter with a terminal-count flag. Everything else stays in one FSM module.

Test Plan:
- FIRST=0x10, LAST=0x13, PUF model DONE 50 cycles after reset with RESPONSE=chal^0xA5, READY=1 -> 4 results (0x10/0xB5 ... 0x13/0xB6); SIGNATURE equals golden model; SWEEP_DONE single pulse; ERR=0.
- FIRST=0xFE, LAST=0x01 -> RESP_CHAL sequence FE, FF, 00, 01; then FINISH.
- TIMEOUT=100, model never asserts DONE for chal 0x05 in sweep 0x04..0x06 -> 0x05 result RESP_DATA=0, RESP_TO=1, ERR=1; 0x06 evaluated normally.
- READY held low 20 cycles during PRESENT -> RESP_* stable, no PUF_RESET pulse, no signature change until handshake.
- ABORT during WAIT of 2nd challenge -> exactly 1 result, SWEEP_DONE pulse, BUSY=0 next cycle. ABORT during PRESENT -> result still delivered, then FINISH.
- RESET_N low mid-WAIT -> all outputs 0 asynchronously; START ignored while BUSY; a later START runs a clean sweep.

Source files
------------

// File: rtl/puf_seq_pkg.sv
// puf_seq_pkg: sequencer state encoding, signature width and the rotate-xor signature fold
package puf_seq_pkg;
  localparam int SIG_W = 16;
  typedef enum logic [2:0] {IDLE, RST, WAIT, PRESENT, FINISH} state_t;
  function automatic logic [SIG_W-1:0] sig_fold(input logic [SIG_W-1:0] sig, input logic [SIG_W-1:0] word);
    return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ word;
  endfunction
endpackage

// File: rtl/puf_timeout_ctr.sv
// puf_timeout_ctr: clearable, enabled up-counter that saturates at TIMEOUT and flags it on tc (clk, rst_n async low, clr, en -> tc)
module puf_timeout_ctr #(
  parameter int TIMEOUT = 1048576,
  parameter int TO_W = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [TO_W-1:0] cnt;
  assign tc = cnt == TO_W'(TIMEOUT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + TO_W'(1);
endmodule

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer: sweeps CHAL_FIRST..CHAL_LAST through the RO PUF (PUF_RESET/CHALLENGE/DONE/RESPONSE), streams results on RESP_VALID/READY and folds them into SIGNATURE
module puf_challenge_sequencer
  import puf_seq_pkg::*;
#(
  parameter int CHAL_W = 8,
  parameter int RESP_W = 8,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT = 1048576,
  parameter int TO_W = 21
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [CHAL_W-1:0] CHAL_FIRST,
  input  logic [CHAL_W-1:0] CHAL_LAST,
  output logic              PUF_RESET,
  output logic [CHAL_W-1:0] PUF_CHALLENGE,
  input  logic              PUF_DONE,
  input  logic [RESP_W-1:0] PUF_RESPONSE,
  output logic              RESP_VALID,
  input  logic              RESP_READY,
  output logic [CHAL_W-1:0] RESP_CHAL,
  output logic [RESP_W-1:0] RESP_DATA,
  output logic              RESP_TO,
  output logic [SIG_W-1:0]  SIGNATURE,
  output logic              BUSY,
  output logic              SWEEP_DONE,
  output logic              ERR
);
  localparam int RC_W = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  state_t state, state_n;
  logic [CHAL_W-1:0] cur, last, resp_chal;
  logic [RESP_W-1:0] resp_data;
  logic [RC_W-1:0] rst_cnt;
  logic [SIG_W-1:0] sig;
  logic resp_to, err, blank, tc, rst_end, done_ok, capture, hs;
  puf_timeout_ctr #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_to (
    .clk(CLK), .rst_n(RESET_N), .clr(state != WAIT), .en(state == WAIT), .tc(tc)
  );
  assign rst_end = rst_cnt == RC_W'(RST_CYCLES - 1);
  assign done_ok = !blank && PUF_DONE;
  assign capture = state == WAIT && !ABORT && (done_ok || tc);
  assign hs = state == PRESENT && RESP_READY;
  always_comb
    state_n = state == IDLE    ? (START ? RST : IDLE)
            : state == RST     ? (ABORT ? FINISH : rst_end ? WAIT : RST)
            : state == WAIT    ? (ABORT ? FINISH : (done_ok || tc) ? PRESENT : WAIT)
            : state == PRESENT ? (!RESP_READY ? PRESENT : (cur == last || ABORT) ? FINISH : RST)
            : IDLE;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      cur <= '0;
      last <= '0;
      rst_cnt <= '0;
      blank <= 1'b0;
      resp_chal <= '0;
      resp_data <= '0;
      resp_to <= 1'b0;
      sig <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      rst_cnt <= state == RST ? rst_cnt + RC_W'(1) : '0;
      blank <= state == RST;
      if (state == IDLE && START) begin
        cur <= CHAL_FIRST;
        last <= CHAL_LAST;
        sig <= '0;
        err <= 1'b0;
      end
      if (capture) begin
        resp_chal <= cur;
        resp_data <= done_ok ? PUF_RESPONSE : '0;
        resp_to <= !done_ok;
        if (!done_ok) err <= 1'b1;
      end
      if (hs) begin
        sig <= sig_fold(sig, SIG_W'({resp_chal, resp_data}));
        if (state_n == RST) cur <= cur + CHAL_W'(1);
      end
    end
  assign PUF_RESET = state == RST;
  assign PUF_CHALLENGE = cur;
  assign RESP_VALID = state == PRESENT;
  assign RESP_CHAL = resp_chal;
  assign RESP_DATA = resp_data;
  assign RESP_TO = resp_to;
  assign SIGNATURE = sig;
  assign BUSY = state != IDLE;
  assign SWEEP_DONE = state == FINISH;
  assign ERR = err;
endmodule
